clock_reset_sequencer: RTL and testbench
========================================

Name: clock_reset_sequencer

Overview:
- Consumes the system clock produced by the PLL wrapper, plus that PLL's lock indication.
- Generates the sequenced, synchronous, active-low resets for the core and the peripherals.
- Holds both resets asserted until lock is stable for a programmed time, then releases core first and peripherals after a further delay.
- Detects lock loss at runtime, re-asserts both resets and counts loss events for status/debug.

Parameters:
- SYNC_STAGES, 2, number of flops in the pll_locked synchronizer (minimum 2).
- LOCK_FILTER, 8, consecutive synchronized-high cycles required before lock is accepted.
- STABLE_CYCLES, 1024, cycles after accepted lock before rstnn_core deasserts.
- PERIPH_DELAY, 16, cycles after rstnn_core deasserts before rstnn_periph deasserts.
- CNT_WIDTH, 16, width of the shared down-counter; must hold max(LOCK_FILTER, STABLE_CYCLES, PERIPH_DELAY).

Ports:
- clk  input  1  system clock (PLL output domain).
- rstnn  input  1  reset; synchronous, active-low.
- pll_locked  input  1  PLL lock flag, asynchronous to clk.
- rstnn_core  output  1  core reset, active-low, registered.
- rstnn_periph  output  1  peripheral reset, active-low, registered.
- seq_ready  output  1  high only in RUN.
- seq_state  output  3  current state encoding.
- lock_loss_count  output  8  saturating count of RUN-to-LOST transitions.

Behaviour:
- Reset (rstnn=0 at a clk edge):
  - state=WAIT_LOCK, counter=LOCK_FILTER-1.
  - rstnn_core=0, rstnn_periph=0, seq_ready=0, lock_loss_count=0.
  - Synchronizer flops cleared to 0.
- Reset mid-operation: same result from any state on the next edge; no partial release.
- Synchronizer: lk_s = pll_locked after SYNC_STAGES flops. All decisions use lk_s only.
- States (encoding): WAIT_LOCK=0, FILTER=1, STABILIZE=2, CORE_UP=3, RUN=4, LOST=5.
- WAIT_LOCK: counter=LOCK_FILTER-1. If lk_s=1, go to FILTER.
- FILTER:
  - lk_s=0: back to WAIT_LOCK; counter reloads.
  - lk_s=1 and counter=0: go to STABILIZE, counter=STABLE_CYCLES-1.
  - Otherwise decrement.
  - LOCK_FILTER=1 means FILTER exits on its first cycle.
- STABILIZE:
  - lk_s=0: go to WAIT_LOCK.
  - counter=0: go to CORE_UP, rstnn_core<=1 on the same edge, counter=PERIPH_DELAY-1.
  - Otherwise decrement.
- CORE_UP:
  - lk_s=0: go to LOST.
  - counter=0: go to RUN, rstnn_periph<=1 and seq_ready<=1 on the same edge.
  - Otherwise decrement.
- RUN: lk_s=0 → go to LOST and increment lock_loss_count, saturating at 255.
- LOST: both resets and seq_ready driven 0 on the edge entering LOST. Next cycle go unconditionally to WAIT_LOCK, so the full sequence restarts.
- Output timing:
  - rstnn_core rises exactly LOCK_FILTER+STABLE_CYCLES cycles after the first FILTER cycle, given lk_s held high.
  - rstnn_periph rises exactly PERIPH_DELAY cycles after rstnn_core.
- Lock loss:
  - Latency from pll_locked falling to reset assertion = SYNC_STAGES+1 edges.
  - Resets assert together, never periph-first.
  - lk_s glitch low in FILTER/STABILIZE restarts the sequence without touching lock_loss_count; only RUN exits count.
- Invariant: rstnn_periph=1 implies rstnn_core=1.
- Counter: single CNT_WIDTH down-counter shared across states, no wrap; a 0 value always causes a transition.
- Elaboration errors: any parameter value 0, or SYNC_STAGES<2.

Decomposition:
- Shared package: state enumeration and widths (STATE_W=3); LOSS_CNT_W=8 constant.
- One sub-module: clock_reset_sync_bit, a SYNC_STAGES-deep flop chain with synchronous clear, reused elsewhere for async inputs.
- FSM, counter and outputs live in the top.

Test Plan (bench uses LOCK_FILTER=4, STABLE_CYCLES=10, PERIPH_DELAY=3, SYNC_STAGES=2):
- rstnn low 5 cycles, pll_locked=1 throughout → all outputs 0 during reset; rstnn_core rises 2+4+10 cycles after first post-reset edge; rstnn_periph and seq_ready rise 3 cycles later; seq_state=4.
- pll_locked high 3 cycles, low 1, then high → FILTER aborts to WAIT_LOCK, counter reloads; release timing measured from second rise; lock_loss_count=0.
- In RUN drop pll_locked → both resets low 3 edges later, seq_state passes 5 then 0, lock_loss_count=1; re-lock repeats full sequence.
- Drop pll_locked during CORE_UP (rstnn_core=1, periph=0) → both 0, lock_loss_count unchanged at 0.
- 300 RUN→LOST cycles → lock_loss_count saturates at 255.
- Assert rstnn during STABILIZE and during RUN → outputs 0 next edge, lock_loss_count cleared, sequence restarts.

Source files
------------

// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and constants for the clock/reset sequencer: state encoding,
// status widths and a small helper for parameter range checks.
package clock_reset_sequencer_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_CORE_UP   = 3'd3,
        ST_RUN       = 3'd4,
        ST_LOST      = 3'd5
    } seq_state_e;

    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clock_reset_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by the
// synchronous active-low reset so downstream logic starts from a known 0.
module clock_reset_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstnn,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("clock_reset_sync_bit: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Sequences core and peripheral resets from a filtered PLL lock flag and
// re-asserts both whenever lock is lost, counting losses seen while running.
module clock_reset_sequencer
    import clock_reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LOCK_FILTER   = 8,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned PERIPH_DELAY  = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  pll_locked,
    output logic                  rstnn_core,
    output logic                  rstnn_periph,
    output logic                  seq_ready,
    output logic [STATE_W-1:0]    seq_state,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    if (SYNC_STAGES < 2 || LOCK_FILTER == 0 || STABLE_CYCLES == 0 ||
        PERIPH_DELAY == 0 || CNT_WIDTH == 0) begin : g_bad_param
        $error("clock_reset_sequencer: invalid parameter set");
    end

    // Every load value is (cycles - 1), so the counter must hold the largest of those.
    if (((max3(LOCK_FILTER, STABLE_CYCLES, PERIPH_DELAY) - 1) >> CNT_WIDTH) != 0)
    begin : g_bad_width
        $error("clock_reset_sequencer: CNT_WIDTH too small for programmed delays");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_FILTER = CNT_WIDTH'(LOCK_FILTER - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_STABLE = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_PERIPH = CNT_WIDTH'(PERIPH_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic lk_s;

    seq_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  rstnn_core_q, rstnn_core_d;
    logic                  rstnn_periph_q, rstnn_periph_d;
    logic                  seq_ready_q, seq_ready_d;

    clock_reset_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rstnn (rstnn),
        .d     (pll_locked),
        .q     (lk_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_cnt_d = loss_cnt_q;

        unique case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = CNT_FILTER;
                if (lk_s) begin
                    state_d = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_FILTER;
                end else if (cnt_q == '0) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = CNT_STABLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STABILIZE: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_FILTER;
                end else if (cnt_q == '0) begin
                    state_d = ST_CORE_UP;
                    cnt_d   = CNT_PERIPH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CORE_UP: begin
                if (!lk_s) begin
                    state_d = ST_LOST;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_LOST;
                    if (loss_cnt_q != LOSS_CNT_MAX) begin
                        loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
                    end
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = CNT_FILTER;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = CNT_FILTER;
            end
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        rstnn_core_d   = (state_d == ST_CORE_UP) || (state_d == ST_RUN);
        rstnn_periph_d = (state_d == ST_RUN);
        seq_ready_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= CNT_FILTER;
            loss_cnt_q     <= '0;
            rstnn_core_q   <= 1'b0;
            rstnn_periph_q <= 1'b0;
            seq_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            loss_cnt_q     <= loss_cnt_d;
            rstnn_core_q   <= rstnn_core_d;
            rstnn_periph_q <= rstnn_periph_d;
            seq_ready_q    <= seq_ready_d;
        end
    end

    assign rstnn_core      = rstnn_core_q;
    assign rstnn_periph    = rstnn_periph_q;
    assign seq_ready       = seq_ready_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: per-edge expectations from a lock run-length
// model go into a queue; a negedge monitor pops and compares every cycle.
module tb_clock_reset_sequencer;

    localparam int SS = 2;
    localparam int LF = 4;
    localparam int SC = 10;
    localparam int PD = 3;
    // Count of consecutive lock-high observations that release core / reach RUN.
    localparam int CORE_AT = 1 + LF + SC;
    localparam int RUN_AT  = CORE_AT + PD;
    localparam int EW      = 14;

    logic       clk = 1'b0;
    logic       rstnn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       rstnn_core;
    logic       rstnn_periph;
    logic       seq_ready;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_count;

    clock_reset_sequencer #(
        .SYNC_STAGES   (SS),
        .LOCK_FILTER   (LF),
        .STABLE_CYCLES (SC),
        .PERIPH_DELAY  (PD),
        .CNT_WIDTH     (16)
    ) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .pll_locked      (pll_locked),
        .rstnn_core      (rstnn_core),
        .rstnn_periph    (rstnn_periph),
        .seq_ready       (seq_ready),
        .seq_state       (seq_state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state: lock delay line, run length of observed lock, loss flag.
    bit lk_hist[$];
    int hi_run = 0;
    int loss = 0;
    bit lost = 0;

    task automatic model_edge(input bit r, input bit l);
        bit         lk_s;
        bit         core;
        bit         per;
        logic [2:0] st;
        if (!r) begin
            lk_hist.delete();
            repeat (SS) lk_hist.push_back(1'b0);
            hi_run = 0;
            loss   = 0;
            lost   = 0;
        end else begin
            lk_s = lk_hist[$];
            lk_hist.pop_back();
            lk_hist.push_front(l);
            if (lost) begin
                lost   = 0;
                hi_run = 0;
            end else if (lk_s) begin
                if (hi_run < RUN_AT) hi_run++;
            end else begin
                if (hi_run >= CORE_AT) begin
                    lost = 1;
                    if (hi_run >= RUN_AT && loss < 255) loss++;
                end
                hi_run = 0;
            end
        end
        if (lost) begin
            st = 3'd5; core = 0; per = 0;
        end else begin
            core = (hi_run >= CORE_AT);
            per  = (hi_run >= RUN_AT);
            if (hi_run == 0)            st = 3'd0;
            else if (hi_run <= LF)      st = 3'd1;
            else if (hi_run <= LF + SC) st = 3'd2;
            else if (!per)              st = 3'd3;
            else                        st = 3'd4;
        end
        exp_q.push_back({core, per, per, st, 8'(loss)});
    endtask

    task automatic step(input bit r, input bit l);
        rstnn      = r;
        pll_locked = l;
        @(posedge clk);
        model_edge(r, l);
        #1;
    endtask

    task automatic hold(input bit r, input bit l, input int n);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {rstnn_core, rstnn_periph, seq_ready, seq_state, lock_loss_count};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL outputs t=%0t got core=%b periph=%b ready=%b state=%0d losses=%0d, expected core=%b periph=%b ready=%b state=%0d losses=%0d",
                             $time, act_v[13], act_v[12], act_v[11], act_v[10:8], act_v[7:0],
                             exp_v[13], exp_v[12], exp_v[11], exp_v[10:8], exp_v[7:0]);
            end
        end
    end

    initial begin
        int cycles;
        repeat (SS) lk_hist.push_back(1'b0);

        // Power-up with lock already high during reset.
        hold(0, 1, 5);
        hold(1, 1, 25);

        // Short lock pulse aborts FILTER, then a clean lock.
        hold(0, 0, 3);
        hold(1, 1, 3);
        step(1, 0);
        hold(1, 1, 25);

        // Lock loss while in RUN, then re-lock.
        step(1, 0);
        hold(1, 1, 25);

        // Lock loss during CORE_UP: no loss counted.
        hold(0, 0, 2);
        hold(1, 1, 16);
        step(1, 0);
        hold(1, 1, 25);

        // Repeated RUN exits drive the loss counter into saturation.
        for (int i = 0; i < 300; i++) begin
            hold(1, 0, $urandom_range(1, 2));
            hold(1, 1, 22 + $urandom_range(0, 4));
        end
        vectors++;
        if (lock_loss_count !== 8'd255) begin
            miscompares++;
            $display("FAIL loss_saturation got %0d expected 255", lock_loss_count);
        end

        // Reset during RUN with a saturated counter, then during STABILIZE.
        step(0, 1);
        hold(1, 1, 25);
        hold(1, 1, 10);
        step(1, 0);
        hold(1, 1, 10);
        step(0, 1);
        hold(1, 1, 25);

        // Randomized lock traffic with occasional resets.
        cycles = 0;
        while (cycles < 1500) begin
            int n_hi;
            int n_lo;
            if ($urandom_range(0, 49) == 0) begin
                n_lo = $urandom_range(1, 3);
                hold(0, $urandom_range(0, 1), n_lo);
                cycles += n_lo;
            end
            n_hi = $urandom_range(1, 30);
            n_lo = $urandom_range(1, 4);
            hold(1, 1, n_hi);
            hold(1, 0, n_lo);
            cycles += n_hi + n_lo;
        end
        hold(1, 1, 25);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
